// File: rtl/hd44780_pkg.sv
// Shared types, opcode masks, address constants and AC helpers for the HD44780 bus receiver.
package hd44780_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StClear,
    StBusy
  } state_e;

  localparam int unsigned ShadowDepth = 32;
  localparam logic [7:0]  ClearChar   = 8'h20;

  // Command masks; the highest set bit selects the instruction.
  localparam logic [7:0] CmdDdram = 8'h80;
  localparam logic [7:0] CmdCgram = 8'h40;
  localparam logic [7:0] CmdFunc  = 8'h20;
  localparam logic [7:0] CmdDisp  = 8'h08;
  localparam logic [7:0] CmdEntry = 8'h04;
  localparam logic [7:0] CmdHome  = 8'h02;
  localparam logic [7:0] CmdClear = 8'h01;

  localparam logic [6:0] Line1Base = 7'h00;
  localparam logic [6:0] Line2Base = 7'h40;
  localparam logic [6:0] Line1End  = 7'h27;
  localparam logic [6:0] Line2End  = 7'h67;

  // Next address counter value after a data write, with the two-line wrap.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic id);
    logic [6:0] nxt;
    if (id) begin
      if (ac == Line1End)      nxt = Line2Base;
      else if (ac == Line2End) nxt = Line1Base;
      else                     nxt = ac + 7'd1;
    end else begin
      if (ac == Line1Base)      nxt = Line2End;
      else if (ac == Line2Base) nxt = Line1End;
      else                      nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // Returns {visible, index}; only the first 16 columns of each line are shadowed.
  function automatic logic [5:0] ac_to_index(input logic [6:0] ac);
    logic [5:0] res;
    if (ac[6:4] == Line1Base[6:4])      res = {1'b1, 1'b0, ac[3:0]};
    else if (ac[6:4] == Line2Base[6:4]) res = {1'b1, 1'b1, ac[3:0]};
    else                                res = 6'd0;
    return res;
  endfunction

endpackage

// File: rtl/hd44780_rx_if.sv
// LCD bus plus shadow read port and status outputs of the receiver.
interface hd44780_rx_if;
  logic       lcd_enable;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       display_on;
  logic [6:0] cursor;
  logic       err_pulse;
  logic [7:0] err_count;

  modport master (
    output lcd_enable, lcd_rs, lcd_rw, lcd_data, rd_addr,
    input  rd_data, busy, display_on, cursor, err_pulse, err_count
  );

  modport slave (
    input  lcd_enable, lcd_rs, lcd_rw, lcd_data, rd_addr,
    output rd_data, busy, display_on, cursor, err_pulse, err_count
  );
endinterface

// File: rtl/hd44780_bus_sync.sv
// Two-flop synchronizer for the LCD bus and falling-edge detect on E.
module hd44780_bus_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       strobe_o,
  output logic       s_rs_o,
  output logic       s_rw_o,
  output logic [7:0] s_data_o
);

  // Packed as {e, rs, rw, data}.
  logic [10:0] meta_q, meta_d;
  logic [10:0] sync_q, sync_d;
  logic        e_prev_q, e_prev_d;

  // Shift the pins through the synchronizer and keep the previous E sample.
  always_comb begin
    meta_d   = {e_i, rs_i, rw_i, data_i};
    sync_d   = meta_q;
    e_prev_d = sync_q[10];
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= '0;
      sync_q   <= '0;
      e_prev_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      e_prev_q <= e_prev_d;
    end
  end

  // Strobe on synchronized E going 1 -> 0; companions come from the same stage.
  always_comb begin
    strobe_o = e_prev_q & ~sync_q[10];
    s_rs_o   = sync_q[9];
    s_rw_o   = sync_q[8];
    s_data_o = sync_q[7:0];
  end

endmodule

// File: rtl/hd44780_rx.sv
// HD44780 bus receiver: decodes writes into a 2x16 DDRAM shadow with busy emulation.
module hd44780_rx
  import hd44780_pkg::*;
#(
  parameter int unsigned BUSY_SHORT_CYC = 2000,
  parameter int unsigned BUSY_LONG_CYC  = 82000
) (
  input logic         clk_clk,
  input logic         reset_reset_n,
  hd44780_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(BUSY_LONG_CYC + 1);
  // EXEC (and the clear fill) already account for part of the busy window.
  localparam logic [CntW-1:0] LoadShort = CntW'(BUSY_SHORT_CYC - 1);
  localparam logic [CntW-1:0] LoadHome  = CntW'(BUSY_LONG_CYC - 1);
  localparam logic [CntW-1:0] LoadClear = CntW'(BUSY_LONG_CYC - 1 - ShadowDepth);

  logic       strobe, s_rs, s_rw;
  logic [7:0] s_data;

  hd44780_bus_sync u_sync (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .e_i      (bus.lcd_enable),
    .rs_i     (bus.lcd_rs),
    .rw_i     (bus.lcd_rw),
    .data_i   (bus.lcd_data),
    .strobe_o (strobe),
    .s_rs_o   (s_rs),
    .s_rw_o   (s_rw),
    .s_data_o (s_data)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      clr_idx_q, clr_idx_d;
  logic            cmd_rs_q, cmd_rs_d;
  logic [7:0]      cmd_data_q, cmd_data_d;
  logic [6:0]      ac_q, ac_d;
  logic            id_q, id_d;
  logic            cgram_q, cgram_d;
  logic            disp_q, disp_d;
  logic            err_pulse_q, err_pulse_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      mem_q [ShadowDepth];

  logic       accept, viol, is_clear, is_home, we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [5:0] vis;

  // Write strobes with RW=1 are reads and never touch state.
  always_comb begin
    accept   = strobe & ~s_rw & (state_q == StIdle);
    viol     = strobe & ~s_rw & (state_q != StIdle);
    is_clear = ~cmd_rs_q & (cmd_data_q == CmdClear);
    is_home  = ~cmd_rs_q & (cmd_data_q[7:1] == CmdHome[7:1]);
  end

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= StIdle;
    else                state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = is_clear ? StClear : StBusy;
      StClear: if (clr_idx_q == 5'(ShadowDepth - 1)) state_d = StBusy;
      StBusy:  if (cnt_q <= CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
  end

  // Command/data execution, clear fill, busy counter and violation tracking.
  always_comb begin
    cnt_d       = cnt_q;
    clr_idx_d   = clr_idx_q;
    cmd_rs_d    = cmd_rs_q;
    cmd_data_d  = cmd_data_q;
    ac_d        = ac_q;
    id_d        = id_q;
    cgram_d     = cgram_q;
    disp_d      = disp_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    we          = 1'b0;
    waddr       = 5'd0;
    wdata       = ClearChar;
    vis         = ac_to_index(ac_q);

    if (viol) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Latch the transfer; the pins may change before EXEC runs.
    if (accept) begin
      cmd_rs_d   = s_rs;
      cmd_data_d = s_data;
    end

    unique case (state_q)
      StExec: begin
        clr_idx_d = 5'd0;
        if (is_clear)     cnt_d = LoadClear;
        else if (is_home) cnt_d = LoadHome;
        else              cnt_d = LoadShort;

        if (cmd_rs_q) begin
          if (!cgram_q) begin
            if (vis[5]) begin
              we    = 1'b1;
              waddr = vis[4:0];
              wdata = cmd_data_q;
            end
            ac_d = ac_step(ac_q, id_q);
          end
        end else if ((cmd_data_q & CmdDdram) != 8'h00) begin
          ac_d    = cmd_data_q[6:0];
          cgram_d = 1'b0;
        end else if ((cmd_data_q & CmdCgram) != 8'h00) begin
          cgram_d = 1'b1;
        end else if ((cmd_data_q & CmdFunc) != 8'h00) begin
          // Function set: bus width / lines / font are not modelled.
        end else if ((cmd_data_q & CmdDisp) != 8'h00) begin
          disp_d = cmd_data_q[2];
        end else if ((cmd_data_q & CmdEntry) != 8'h00) begin
          id_d = cmd_data_q[1];
        end else if ((cmd_data_q & CmdHome) != 8'h00) begin
          ac_d    = 7'd0;
          cgram_d = 1'b0;
        end else if ((cmd_data_q & CmdClear) != 8'h00) begin
          ac_d    = 7'd0;
          id_d    = 1'b1;
          cgram_d = 1'b0;
        end
      end
      StClear: begin
        we        = 1'b1;
        waddr     = clr_idx_q;
        wdata     = ClearChar;
        clr_idx_d = clr_idx_q + 5'd1;
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
      end
      default: ;
    endcase

    // Forward a same-cycle write so rd_data is current one cycle after the update.
    if (we && (waddr == bus.rd_addr)) rd_data_d = wdata;
    else                               rd_data_d = mem_q[bus.rd_addr];
  end

  // Control and status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q       <= '0;
      clr_idx_q   <= 5'd0;
      cmd_rs_q    <= 1'b0;
      cmd_data_q  <= 8'h00;
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      cgram_q     <= 1'b0;
      disp_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 8'h00;
      rd_data_q   <= ClearChar;
    end else begin
      cnt_q       <= cnt_d;
      clr_idx_q   <= clr_idx_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_data_q  <= cmd_data_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      cgram_q     <= cgram_d;
      disp_q      <= disp_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // DDRAM shadow; reset restores blanks at once without a fill sequence.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < ShadowDepth; i++) mem_q[i] <= ClearChar;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.display_on = disp_q;
  assign bus.cursor     = ac_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_hd44780_rx.sv
// Scoreboard bench for hd44780_rx: stimulus pushes expectations, monitors pop and compare.
module tb_hd44780_rx;

  localparam int SHORT = 40;
  localparam int LONG  = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hd44780_rx_if bus ();

  hd44780_rx #(
    .BUSY_SHORT_CYC (SHORT),
    .BUSY_LONG_CYC  (LONG)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  typedef struct {int addr; int exp;} rd_t;
  typedef struct {int sel;  int exp;} st_t;

  rd_t exp_rd[$];
  st_t exp_st[$];
  int  exp_busy[$];
  int  exp_err[$];

  int n_checks = 0;
  int n_fail   = 0;
  int err_model = 0;
  int busy_run = 0;
  bit err_prev = 0;
  bit rd_req = 0, st_req = 0, rd_vld = 0, st_vld = 0;
  rd_t mon_r;
  st_t mon_s;
  string st_name [4] = '{"busy", "cursor", "err_count", "display_on"};

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int st_val(int sel);
    case (sel)
      0:       return int'(bus.busy);
      1:       return int'(bus.cursor);
      2:       return int'(bus.err_count);
      default: return int'(bus.display_on);
    endcase
  endfunction

  // Request valids become visible one clock after they are issued.
  always @(posedge clk) begin
    rd_vld <= rd_req;
    st_vld <= st_req;
  end

  // Read / status monitor.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        mon_r = exp_rd.pop_front();
        chk($sformatf("rd_data[%0d]", mon_r.addr), int'(bus.rd_data), mon_r.exp);
      end
    end
    if (st_vld) begin
      if (exp_st.size() == 0) chk("st_unexpected", 1, 0);
      else begin
        mon_s = exp_st.pop_front();
        chk(st_name[mon_s.sel], st_val(mon_s.sel), mon_s.exp);
      end
    end
  end

  // Busy-window monitor: each completed busy run is compared with the queued length.
  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else if (bus.busy) busy_run++;
    else if (busy_run != 0) begin
      if (exp_busy.size() == 0) chk("busy_unexpected", busy_run, 0);
      else chk("busy_cycles", busy_run, exp_busy.pop_front());
      busy_run = 0;
    end
  end

  // Violation monitor.
  always @(negedge clk) begin
    if (!rst_n) err_prev = 0;
    else begin
      if (bus.err_pulse) begin
        chk("err_pulse_width", int'(err_prev), 0);
        if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_count_on_pulse", int'(bus.err_count), exp_err.pop_front());
      end
      err_prev = bus.err_pulse;
    end
  end

  task automatic rd_chk(input int a, input int e);
    rd_t r;
    r.addr = a;
    r.exp  = e;
    bus.rd_addr = 5'(a);
    exp_rd.push_back(r);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic st_chk(input int sel, input int e);
    st_t s;
    s.sel = sel;
    s.exp = e;
    exp_st.push_back(s);
    st_req = 1'b1;
    @(negedge clk);
    st_req = 1'b0;
  endtask

  task automatic rd_all(input int e);
    for (int i = 0; i < 32; i++) rd_chk(i, e);
  endtask

  // Bus transfer honouring 3-cycle setup, 2-cycle E high and 1-cycle hold.
  task automatic pulse(input bit rs, input bit rw, input logic [7:0] d);
    bus.lcd_rs   = rs;
    bus.lcd_rw   = rw;
    bus.lcd_data = d;
    repeat (3) @(negedge clk);
    bus.lcd_enable = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    bit long_busy;
    long_busy = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    exp_busy.push_back(long_busy ? LONG : SHORT);
    pulse(rs, 1'b0, d);
  endtask

  task automatic viol(input bit rs, input logic [7:0] d);
    if (err_model < 255) err_model++;
    exp_err.push_back(err_model);
    pulse(rs, 1'b0, d);
  endtask

  task automatic wait_idle();
    int n;
    repeat (4) @(negedge clk);
    n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wr_w(input bit rs, input logic [7:0] d);
    wr(rs, d);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.lcd_enable = 1'b0;
    bus.lcd_rs     = 1'b0;
    bus.lcd_rw     = 1'b0;
    bus.lcd_data   = 8'h00;
    bus.rd_addr    = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    st_chk(0, 0); st_chk(1, 0); st_chk(2, 0); st_chk(3, 0);
    rd_all(8'h20);

    // DDRAM set to line 2, one character.
    wr_w(0, 8'hC0);
    wr_w(1, 8'h41);
    rd_chk(16, 8'h41);
    st_chk(1, 8'h41);

    // Increment wrap 0x27 -> 0x40 with discarded byte, then decrement wrap 0x40 -> 0x27.
    wr_w(0, 8'hA7);
    wr_w(1, 8'h55);
    st_chk(1, 8'h40);
    rd_chk(16, 8'h41);
    wr_w(0, 8'h04);
    wr_w(0, 8'hC0);
    wr_w(1, 8'h55);
    rd_chk(16, 8'h55);
    st_chk(1, 8'h27);

    // Display control.
    wr_w(0, 8'h0C);
    st_chk(3, 1);

    // Fill both lines with '0'.
    wr_w(0, 8'h06);
    wr_w(0, 8'h80);
    for (int i = 0; i < 16; i++) wr_w(1, 8'h30);
    wr_w(0, 8'hC0);
    for (int i = 0; i < 16; i++) wr_w(1, 8'h30);
    st_chk(1, 8'h50);
    rd_all(8'h30);

    // Home: long busy, AC back to 0, shadow kept.
    wr_w(0, 8'h02);
    st_chk(1, 0);
    rd_chk(5, 8'h30);

    // Clear with ID=0 beforehand: blanks, AC=0, ID forced back to increment.
    wr_w(0, 8'hC5);
    wr_w(0, 8'h04);
    wr_w(0, 8'h01);
    st_chk(1, 0);
    rd_all(8'h20);
    wr_w(1, 8'h31);
    st_chk(1, 1);
    rd_chk(0, 8'h31);

    // Data strobe during short busy is discarded and counted.
    wr(0, 8'h80);
    viol(1, 8'h77);
    wait_idle();
    rd_chk(0, 8'h31);
    st_chk(1, 0);
    st_chk(2, 1);

    // Saturate the violation counter.
    for (int k = 0; k < 52; k++) begin
      wr(0, 8'h00);
      for (int j = 0; j < 5; j++) viol(0, 8'h00);
      wait_idle();
    end
    st_chk(2, 255);

    // CGRAM mode swallows data without moving AC.
    wr_w(0, 8'h40);
    wr_w(1, 8'h1F);
    rd_chk(0, 8'h31);
    st_chk(1, 0);

    // Read strobe: no busy, no error, no change.
    pulse(1, 1, 8'h99);
    wait_idle();
    st_chk(1, 0);
    st_chk(2, 255);
    rd_chk(0, 8'h31);

    // DDRAM set leaves CGRAM mode.
    wr_w(0, 8'h80);
    wr_w(1, 8'h42);
    rd_chk(0, 8'h42);
    st_chk(1, 1);

    // Reset in the middle of a clear fill.
    wr_w(0, 8'hCF);
    wr_w(1, 8'h5A);
    rd_chk(31, 8'h5A);
    pulse(0, 0, 8'h01);
    repeat (4) @(negedge clk);
    rd_chk(31, 8'h5A);
    st_chk(0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    err_model = 0;
    @(negedge clk);
    st_chk(0, 0); st_chk(1, 0); st_chk(2, 0); st_chk(3, 0);
    rd_chk(31, 8'h20);
    rst_n = 1'b1;
    @(negedge clk);
    rd_all(8'h20);
    st_chk(0, 0);

    repeat (5) @(negedge clk);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("st_queue_empty", exp_st.size(), 0);
    chk("busy_queue_empty", exp_busy.size(), 0);
    chk("err_queue_empty", exp_err.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hd44780_rx.md
# hd44780_rx

Receiving end of the character-LCD bus (lcd_rs, lcd_rw, lcd_enable, lcd_data) that the system drives toward the HD44780 display. It synchronizes the bus and decodes each write on the falling edge of lcd_enable. It keeps a 32-character DDRAM shadow (2×16), the address counter and a busy-time emulation. The shadow serves the VGA on-screen LCD mirror and the testbench scoreboard, and protocol violations are flagged.

## Interface
Parameters:
- BUSY_SHORT_CYC, 2000, busy cycles after a normal command or data write (40 µs at 50 MHz).
- BUSY_LONG_CYC, 82000, busy cycles after clear or home (1.64 ms).

Ports:
- clk_clk  in  1  system clock; the single clock for the block.
- reset_reset_n  in  1  reset, asynchronous, active-low.
- lcd_enable  in  1  LCD E strobe, asynchronous to clk_clk.
- lcd_rs  in  1  register select: 0 = command, 1 = data.
- lcd_rw  in  1  1 = read. Reads are ignored.
- lcd_data  in  8  LCD data bus.
- rd_addr  in  5  shadow read index. 0–15 = line 1, 16–31 = line 2.
- rd_data  out  8  shadow character, registered.
- busy  out  1  emulated busy flag.
- display_on  out  1  D bit from the last display-control command.
- cursor  out  7  current HD44780 address counter (AC).
- err_pulse  out  1  one-cycle pulse on a protocol violation.
- err_count  out  8  violation count, saturating at 255.

## Operation
- Input conditioning: lcd_enable, lcd_rs, lcd_rw and lcd_data each pass through a 2-flop synchronizer.
- A strobe is a falling edge of synchronized E, meaning the previous sample was 1 and the current sample is 0.
- RS, RW and data are taken from the synchronized stage in the same cycle the strobe is detected.
- Strobes with RW=1 are ignored: no state change and no error.
- A strobe while busy=1, or while a clear fill is in progress, is discarded and counted as a violation (err_pulse plus err_count increment).
- Command decode (RS=0), highest set bit wins:
  - 1aaaaaaa: AC = aaaaaaa; mode becomes DDRAM.
  - 01xxxxxx: mode becomes CGRAM; later data writes are discarded.
  - 001xxxxx: function set; no state change.
  - 00001dcb: display_on = d.
  - 000001is: ID = i; s is ignored.
  - 0000001x: home. AC = 0, mode becomes DDRAM; long busy.
  - 00000001: clear. Fill the shadow with 0x20, set AC = 0, ID = 1, mode becomes DDRAM; long busy.
  - 00000000: no state change, short busy.
- Data write (RS=1):
  - In DDRAM mode, the byte is stored when AC is visible, then AC steps.
  - Visible addresses: 0x00–0x0F map to indices 0–15; 0x40–0x4F map to indices 16–31.
  - When AC is not visible, the byte is discarded but AC still steps. This is not an error.
  - In CGRAM mode, the byte is discarded and AC is unchanged.
- AC step when ID=1 (increment): 0x27 → 0x40, 0x67 → 0x00, otherwise +1.
- AC step when ID=0 (decrement): 0x00 → 0x67, 0x40 → 0x27, otherwise −1.
- A DDRAM set to an address in 0x28–0x3F or 0x68–0x7F is accepted as written.
- FSM states:
  - IDLE: on a valid strobe, go to EXEC.
  - EXEC: apply the command or data in one cycle. Go to CLEAR for a clear command, otherwise to BUSY.
  - CLEAR: write one shadow entry per cycle, indices 0..31 (32 cycles), then go to BUSY.
  - BUSY: the counter loads at entry with BUSY_LONG_CYC for clear/home or BUSY_SHORT_CYC otherwise. It counts down and returns to IDLE when it reaches 1.
- busy = 1 in EXEC, CLEAR and BUSY.
- Total busy time from EXEC through the end of BUSY is exactly the parameter value. Clear fill cycles count toward BUSY_LONG_CYC.
- The read port is always live. During CLEAR it returns the partially filled contents.

## Timing
- Reset values: every shadow entry 0x20, rd_data 0x20, busy 0, display_on 0, cursor 0, err_pulse 0, err_count 0, ID 1, mode DDRAM, FSM IDLE.
- Strobe latency: pin E falls at cycle 0 → strobe detected at cycle 2 → EXEC at cycle 3, where busy rises → shadow and cursor updated at the end of cycle 3.
- Read latency: rd_data reflects rd_addr one cycle later. A write at the end of cycle 3 is visible on rd_data at cycle 4 for an rd_addr held constant.
- Bus rule: lcd_rs, lcd_rw and lcd_data must be stable at least 3 clk_clk cycles before E falls and 1 cycle after.
- E high must last at least 2 cycles; shorter pulses may be missed. A missed pulse is not an error.
- A violation strobe and the FSM leaving BUSY in the same cycle: the strobe counts as a violation and is discarded.
- Reset asserted mid-operation (CLEAR or BUSY) returns the block to the reset state immediately. This includes a full 0x20 shadow with no fill sequence.

## Structure
- Package hd44780_pkg holds:
  - FSM state enum (IDLE, EXEC, CLEAR, BUSY).
  - Command opcode masks and the clear fill character 0x20.
  - Line base addresses 0x00/0x40 and wrap constants 0x27/0x67.
  - Function ac_step(ac, id) and function ac_to_index(ac) returning {visible, index[4:0]}.
- One sub-module, hd44780_bus_sync: the 2-flop synchronizer for E, RS, RW and data, plus the falling-edge detect, producing strobe, s_rs, s_rw and s_data.

## Test plan
- Reset release → rd_data reads 0x20 at every index; busy=0, cursor=0, err_count=0.
- DDRAM set 0xC0, then data 'A' (0x41) after busy clears → index 16 = 0x41, cursor = 0x41, busy high for exactly BUSY_SHORT_CYC cycles.
- Increment mode with AC=0x27, data 0x55 → byte discarded, cursor = 0x40. Entry mode 0x04, DDRAM set 0xC0, data 0x55 → index 16 = 0x55, cursor = 0x27.
- Fill indices 0–31 with 0x30, then clear 0x01 → all entries 0x20 within 33 cycles of EXEC, cursor 0, busy high for exactly BUSY_LONG_CYC cycles.
- Data strobe 10 cycles into a short busy → err_pulse for one cycle, err_count = 1, shadow unchanged. 256 such violations → err_count holds at 255.
- CGRAM set 0x40, then data 0x1F → shadow and cursor unchanged. A strobe with RW=1 → no change and no error. Reset asserted during CLEAR → reset values on the next cycle.
